// File: rtl/armleocpu_regfile_sched_if.sv
// Bus bundle between the register-file scheduler and its neighbours:
// decode/issue, the two writeback sources (ALU, load unit) and the 2R1W regfile.
interface armleocpu_regfile_sched_if;
  // decode / issue side
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_rs1_read;
  logic [4:0]  issue_rs1_addr;
  logic        issue_rs2_read;
  logic [4:0]  issue_rs2_addr;
  logic        issue_rd_reserve;
  logic [4:0]  issue_rd_addr;
  logic        operands_valid;

  // register file read ports
  logic        rs1_read;
  logic [4:0]  rs1_addr;
  logic        rs2_read;
  logic [4:0]  rs2_addr;

  // writeback requester 0 (ALU)
  logic        wb0_valid;
  logic        wb0_ready;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;

  // writeback requester 1 (load unit)
  logic        wb1_valid;
  logic        wb1_ready;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;

  // register file write port
  logic        rd_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;

  // sticky protocol error
  logic        wb_error;

  // scheduler side
  modport slave (
    input  issue_valid, issue_rs1_read, issue_rs1_addr, issue_rs2_read, issue_rs2_addr,
    input  issue_rd_reserve, issue_rd_addr,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output issue_ready, operands_valid,
    output rs1_read, rs1_addr, rs2_read, rs2_addr,
    output wb0_ready, wb1_ready,
    output rd_write, rd_addr, rd_wdata, wb_error
  );

  // surrounding pipeline side
  modport master (
    output issue_valid, issue_rs1_read, issue_rs1_addr, issue_rs2_read, issue_rs2_addr,
    output issue_rd_reserve, issue_rd_addr,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  issue_ready, operands_valid,
    input  rs1_read, rs1_addr, rs2_read, rs2_addr,
    input  wb0_ready, wb1_ready,
    input  rd_write, rd_addr, rd_wdata, wb_error
  );
endinterface

// File: rtl/armleocpu_regfile_sched.sv
// Register file scheduler: pending-register scoreboard gating issue, plus an
// arbiter sharing the single regfile write port between ALU and load writeback.
// RR_ARB = 1 alternates between the two sources when both request;
// RR_ARB = 0 always favours wb0.
module armleocpu_regfile_sched #(
  parameter int RR_ARB = 1
) (
  input logic clk,
  input logic rst_n,
  armleocpu_regfile_sched_if.slave bus
);

  localparam logic RR_EN = (RR_ARB != 0);

  // state
  logic [31:1] pending_reg;
  logic [31:1] pending_next;
  logic        rr_last_reg;        // 1: wb1 was granted last, 0: wb0 was
  logic        operands_valid_reg;
  logic        wb_error_reg;

  // x0 is never pending; the zero bit lets any 5-bit index be looked up directly
  logic [31:0] pending_vec;
  assign pending_vec = {pending_reg, 1'b0};

  // issue side
  logic hazard;
  logic handshake;
  logic any_read;

  assign hazard = (bus.issue_rs1_read & pending_vec[bus.issue_rs1_addr])
                | (bus.issue_rs2_read & pending_vec[bus.issue_rs2_addr])
                | (bus.issue_rd_reserve & (bus.issue_rd_addr != 5'd0)
                   & pending_vec[bus.issue_rd_addr]);

  assign bus.issue_ready = ~hazard;
  assign handshake       = bus.issue_valid & ~hazard;
  assign any_read        = bus.issue_rs1_read | bus.issue_rs2_read;

  assign bus.rs1_read = handshake & bus.issue_rs1_read;
  assign bus.rs2_read = handshake & bus.issue_rs2_read;
  assign bus.rs1_addr = bus.issue_rs1_addr;
  assign bus.rs2_addr = bus.issue_rs2_addr;
  assign bus.operands_valid = operands_valid_reg;

  // writeback side
  logic        grant0;
  logic        grant1;
  logic        grant_any;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;
  logic        write_en;

  // Arbitration: a lone requester always wins; on contention either alternate
  // away from the last winner or let wb0 win outright.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.wb0_valid && bus.wb1_valid) begin
      if (RR_EN && !rr_last_reg) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = bus.wb0_valid;
      grant1 = bus.wb1_valid;
    end
  end

  assign grant_any  = grant0 | grant1;
  assign grant_addr = grant1 ? bus.wb1_addr : (grant0 ? bus.wb0_addr : 5'd0);
  assign grant_data = grant1 ? bus.wb1_data : (grant0 ? bus.wb0_data : 32'd0);
  // a grant to x0 is accepted but never reaches the regfile
  assign write_en   = grant_any & (grant_addr != 5'd0);

  assign bus.wb0_ready = grant0;
  assign bus.wb1_ready = grant1;
  assign bus.rd_write  = write_en;
  assign bus.rd_addr   = grant_addr;
  assign bus.rd_wdata  = grant_data;
  assign bus.wb_error  = wb_error_reg;

  // Per-register scoreboard update. A reservation and a writeback can never
  // target the same register in one cycle (the pending register stalls issue),
  // so the ordering of set over clear only matters for robustness.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      logic set_bit;
      logic clr_bit;
      assign set_bit = handshake & bus.issue_rd_reserve & (bus.issue_rd_addr == 5'(gi));
      assign clr_bit = write_en & (grant_addr == 5'(gi));
      assign pending_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : pending_reg[gi]);
    end
  endgenerate

  // Scoreboard, arbitration history, read-valid pipeline and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg        <= '0;
      rr_last_reg        <= 1'b1;
      operands_valid_reg <= 1'b0;
      wb_error_reg       <= 1'b0;
    end else begin
      pending_reg        <= pending_next;
      operands_valid_reg <= handshake & any_read;
      if (grant_any) begin
        rr_last_reg <= grant1;
      end
      if (write_en && !pending_vec[grant_addr]) begin
        wb_error_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_regfile_sched.sv
// Self-checking bench for armleocpu_regfile_sched: directed vector table,
// hand-written reset/priority sequences and randomized traffic against a model.
module tb_armleocpu_regfile_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  armleocpu_regfile_sched_if ifa ();
  armleocpu_regfile_sched_if ifb ();

  armleocpu_regfile_sched #(.RR_ARB(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(ifa));
  armleocpu_regfile_sched #(.RR_ARB(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic iv; logic r1; logic [4:0] a1; logic r2; logic [4:0] a2; logic rr; logic [4:0] ard;
    logic w0v; logic [4:0] w0a; logic [31:0] w0d;
    logic w1v; logic [4:0] w1a; logic [31:0] w1d;
    logic e_ready; logic e_w0r; logic e_w1r; logic e_rdw; logic [4:0] e_rda; logic [31:0] e_rdd;
    logic e_opv; logic e_err;
  } vec_t;

  vec_t vecs[$];

  // reference model of the scheduler state (RR_ARB = 1 instance)
  bit m_pend[32];
  bit m_last;
  bit m_opv;
  bit m_err;

  function automatic vec_t mk(
      input logic iv, input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
      input logic rr, input logic [4:0] ard,
      input logic w0v, input logic [4:0] w0a, input logic [31:0] w0d,
      input logic w1v, input logic [4:0] w1a, input logic [31:0] w1d,
      input logic e_ready, input logic e_w0r, input logic e_w1r, input logic e_rdw,
      input logic [4:0] e_rda, input logic [31:0] e_rdd, input logic e_opv, input logic e_err);
    vec_t v;
    v.iv = iv; v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2; v.rr = rr; v.ard = ard;
    v.w0v = w0v; v.w0a = w0a; v.w0d = w0d; v.w1v = w1v; v.w1a = w1a; v.w1d = w1d;
    v.e_ready = e_ready; v.e_w0r = e_w0r; v.e_w1r = e_w1r; v.e_rdw = e_rdw;
    v.e_rda = e_rda; v.e_rdd = e_rdd; v.e_opv = e_opv; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    ifa.issue_valid = v.iv;      ifa.issue_rs1_read = v.r1; ifa.issue_rs1_addr = v.a1;
    ifa.issue_rs2_read = v.r2;   ifa.issue_rs2_addr = v.a2;
    ifa.issue_rd_reserve = v.rr; ifa.issue_rd_addr = v.ard;
    ifa.wb0_valid = v.w0v; ifa.wb0_addr = v.w0a; ifa.wb0_data = v.w0d;
    ifa.wb1_valid = v.w1v; ifa.wb1_addr = v.w1a; ifa.wb1_data = v.w1d;
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    chk({tag, " issue_ready"}, ifa.issue_ready, v.e_ready);
    chk({tag, " rs1_read"}, ifa.rs1_read, v.iv & v.e_ready & v.r1);
    chk({tag, " rs2_read"}, ifa.rs2_read, v.iv & v.e_ready & v.r2);
    chk({tag, " rs1_addr"}, ifa.rs1_addr, v.a1);
    chk({tag, " rs2_addr"}, ifa.rs2_addr, v.a2);
    chk({tag, " wb0_ready"}, ifa.wb0_ready, v.e_w0r);
    chk({tag, " wb1_ready"}, ifa.wb1_ready, v.e_w1r);
    chk({tag, " rd_write"}, ifa.rd_write, v.e_rdw);
    if (v.e_rdw) begin
      chk({tag, " rd_addr"}, ifa.rd_addr, v.e_rda);
      chk({tag, " rd_wdata"}, ifa.rd_wdata, v.e_rdd);
    end
    chk({tag, " operands_valid"}, ifa.operands_valid, v.e_opv);
    chk({tag, " wb_error"}, ifa.wb_error, v.e_err);
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last = 1'b1;
    m_opv  = 1'b0;
    m_err  = 1'b0;
  endtask

  // Expected outputs from the model: an instruction may go only if nothing it
  // touches is awaiting a writeback; contending writebacks alternate.
  task automatic model_eval(input vec_t vin, output vec_t vout);
    int win;
    vout = vin;
    vout.e_ready = !((vin.r1 && m_pend[vin.a1]) || (vin.r2 && m_pend[vin.a2]) ||
                     (vin.rr && vin.ard != 0 && m_pend[vin.ard]));
    win = -1;
    if (vin.w0v && vin.w1v) win = (m_last == 1'b0) ? 1 : 0;
    else if (vin.w0v) win = 0;
    else if (vin.w1v) win = 1;
    vout.e_w0r = (win == 0);
    vout.e_w1r = (win == 1);
    vout.e_rda = (win == 1) ? vin.w1a : vin.w0a;
    vout.e_rdd = (win == 1) ? vin.w1d : vin.w0d;
    vout.e_rdw = (win >= 0) && (vout.e_rda != 0);
    vout.e_opv = m_opv;
    vout.e_err = m_err;
  endtask

  task automatic model_commit(input vec_t v);
    bit hs;
    hs = v.iv && v.e_ready;
    if (v.e_rdw) begin
      if (!m_pend[v.e_rda]) m_err = 1'b1;
      m_pend[v.e_rda] = 1'b0;
    end
    if (hs && v.rr && v.ard != 0) m_pend[v.ard] = 1'b1;
    m_opv = hs && (v.r1 || v.r2);
    if (v.e_w0r || v.e_w1r) m_last = v.e_w1r;
  endtask

  task automatic idle_all();
    vec_t z;
    z = '{default: 0};
    drive_vec(z);
    ifb.issue_valid = 0; ifb.issue_rs1_read = 0; ifb.issue_rs1_addr = 0;
    ifb.issue_rs2_read = 0; ifb.issue_rs2_addr = 0;
    ifb.issue_rd_reserve = 0; ifb.issue_rd_addr = 0;
    ifb.wb0_valid = 0; ifb.wb0_addr = 0; ifb.wb0_data = 0;
    ifb.wb1_valid = 0; ifb.wb1_addr = 0; ifb.wb1_data = 0;
  endtask

  // leaves the bench 1 time unit after a rising edge with reset released
  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t e;
    logic        rq_v[2];
    logic [4:0]  rq_a[2];
    logic [31:0] rq_d[2];
    logic [4:0]  pq[$];

    idle_all();
    reset_dut();

    // ---------------- reset state ----------------
    v = '{default: 0};
    v.r1 = 1; v.a1 = 5; v.r2 = 1; v.a2 = 31; v.rr = 1; v.ard = 7;
    model_eval(v, e);
    drive_vec(e);
    #2;
    check_outputs(e, "reset");
    chk("reset fp wb_error", ifb.wb_error, 1'b0);
    $display("reset  ready=%0b opv=%0b err=%0b", ifa.issue_ready, ifa.operands_valid, ifa.wb_error);
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    //            iv r1 a1 r2 a2 rr ard  w0v w0a w0d           w1v w1a w1d           rdy w0r w1r rdw rda rdd           opv err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h11,        1, 0, 32'h22,        1, 1, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h33,        1, 0, 32'h22,        1, 0, 1, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h33,        1, 0, 32'h44,        1, 1, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h55,        1, 0, 32'h44,        1, 0, 1, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0,  1, 5, 32'h12345678,  0, 0, 32'h0,         0, 1, 0, 1, 5, 32'h12345678,  0, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,         1, 0, 32'hDEADBEEF,  1, 0, 1, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0,  0, 0, 32'h0,         1, 3, 32'h33,        0, 0, 1, 1, 3, 32'h33,        0, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 4, 32'h44,        0, 0, 32'h0,         1, 1, 0, 1, 4, 32'h44,        0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 7, 32'h77,        0, 0, 32'h0,         1, 1, 0, 1, 7, 32'h77,        0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 1));
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      #2;
      check_outputs(vecs[i], $sformatf("vec%0d", i));
      $display("vec%0d ready=%0b wb0_ready=%0b wb1_ready=%0b rd_write=%0b rd_addr=%0d opv=%0b err=%0b",
               i, ifa.issue_ready, ifa.wb0_ready, ifa.wb1_ready, ifa.rd_write, ifa.rd_addr,
               ifa.operands_valid, ifa.wb_error);
      @(posedge clk); #1;
    end
    idle_all();

    // ---------------- fixed priority instance: wb0 wins every contention ----------------
    for (int i = 0; i < 4; i++) begin
      ifb.wb0_valid = 1; ifb.wb0_addr = 0; ifb.wb0_data = $urandom;
      ifb.wb1_valid = 1; ifb.wb1_addr = 0; ifb.wb1_data = 32'hDEADBEEF;
      #2;
      chk($sformatf("fp%0d wb0_ready", i), ifb.wb0_ready, 1'b1);
      chk($sformatf("fp%0d wb1_ready", i), ifb.wb1_ready, 1'b0);
      chk($sformatf("fp%0d rd_write", i), ifb.rd_write, 1'b0);
      $display("fp%0d wb0_ready=%0b wb1_ready=%0b", i, ifb.wb0_ready, ifb.wb1_ready);
      @(posedge clk); #1;
    end
    idle_all();

    // ---------------- reset while x9 is pending ----------------
    ifa.issue_valid = 1; ifa.issue_rd_reserve = 1; ifa.issue_rd_addr = 9;
    #2;
    chk("rst reserve9 ready", ifa.issue_ready, 1'b1);
    @(posedge clk); #1;
    ifa.issue_rd_reserve = 0; ifa.issue_rs1_read = 1; ifa.issue_rs1_addr = 9;
    #2;
    chk("rst x9 stalled", ifa.issue_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst x9 ready at once", ifa.issue_ready, 1'b1);
    chk("rst wb_error cleared", ifa.wb_error, 1'b0);
    chk("rst operands_valid", ifa.operands_valid, 1'b0);
    $display("rst mid-stream ready=%0b err=%0b", ifa.issue_ready, ifa.wb_error);
    idle_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    ifa.wb0_valid = 1; ifa.wb0_addr = 9; ifa.wb0_data = 32'h99;
    #2;
    chk("rst inflight wb0_ready", ifa.wb0_ready, 1'b1);
    chk("rst inflight rd_write", ifa.rd_write, 1'b1);
    @(posedge clk); #1;
    idle_all();
    #2;
    chk("rst inflight wb_error", ifa.wb_error, 1'b1);
    $display("rst inflight err=%0b", ifa.wb_error);

    // ---------------- randomized traffic against the model ----------------
    reset_dut();
    for (int n = 0; n < 2; n++) begin
      rq_v[n] = 0; rq_a[n] = 0; rq_d[n] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      pq.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) pq.push_back(5'(r));
      // a requester keeps its request unchanged until it is granted
      for (int n = 0; n < 2; n++) begin
        if (!rq_v[n]) begin
          rq_v[n] = ($urandom_range(0, 99) < 55);
          if (pq.size() > 0 && $urandom_range(0, 99) < 80)
            rq_a[n] = pq[$urandom_range(0, pq.size() - 1)];
          else
            rq_a[n] = 5'($urandom_range(0, 7));
          rq_d[n] = $urandom;
        end
      end
      v = '{default: 0};
      v.iv = 1'($urandom_range(0, 1));
      v.r1 = 1'($urandom_range(0, 1)); v.a1 = 5'($urandom_range(0, 7));
      v.r2 = 1'($urandom_range(0, 1)); v.a2 = 5'($urandom_range(0, 7));
      v.rr = 1'($urandom_range(0, 1)); v.ard = 5'($urandom_range(0, 7));
      v.w0v = rq_v[0]; v.w0a = rq_a[0]; v.w0d = rq_d[0];
      v.w1v = rq_v[1]; v.w1a = rq_a[1]; v.w1d = rq_d[1];
      model_eval(v, e);
      drive_vec(e);
      #2;
      check_outputs(e, $sformatf("rnd%0d", c));
      $display("rnd%0d ready=%0b wb0_ready=%0b wb1_ready=%0b rd_write=%0b rd_addr=%0d err=%0b",
               c, ifa.issue_ready, ifa.wb0_ready, ifa.wb1_ready, ifa.rd_write, ifa.rd_addr,
               ifa.wb_error);
      model_commit(e);
      if (e.e_w0r) rq_v[0] = 0;
      if (e.e_w1r) rq_v[1] = 0;
      @(posedge clk); #1;
    end
    idle_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
